// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Forwarding and hazard controller for a classic 5-stage MIPS pipeline.
//   * Picks the EX-stage operand source for rs (A) and rt (B):
//     EX/MEM result first, then MEM/WB result, else the register file.
//   * Detects load-use hazards between the load in EX and the instruction in
//     ID and inserts a single bubble for each one.
//   * Freezes the whole pipe while a load in MEM waits for the data memory.
//   * Keeps saturating bubble/freeze counters and a sticky timeout flag raised
//     once a single load has waited MAX_WAIT cycles.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   ifid_rs/rt, ifid_uses_rt   source registers of the instruction in ID
//   idex_rs/rt/rd, idex_mem_read     instruction in EX
//   exmem_rd/reg_write/mem_read, mem_ready   instruction in MEM, memory handshake
//   memwb_rd/reg_write         instruction in WB
//   forward_a/forward_b        00 regfile, 10 EX/MEM, 01 MEM/WB
//   pc_write, ifid_write, idex_bubble, pipe_freeze   pipeline control (Mealy)
//   stall_cnt, freeze_cnt      saturating event counters
//   mem_timeout                sticky long-wait flag
//   fsm_state                  00 IDLE, 01 LOAD_USE, 10 MEM_WAIT
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  ifid_uses_rt,
    input  logic [REG_ADDR_W-1:0] idex_rs,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic                  exmem_mem_read,
    input  logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_reg_write,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      freeze_cnt,
    output logic                  mem_timeout,
    output logic [1:0]            fsm_state
);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_LOAD_USE = 2'b01;
    localparam logic [1:0] ST_MEM_WAIT = 2'b10;

    localparam logic [7:0]       WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [7:0]       WAIT_SAT   = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    logic [1:0]       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic wait_cond;
    logic lu_cond;

    // Operand 0 is rs (A), operand 1 is rt (B); both use identical priority.
    logic [REG_ADDR_W-1:0] op_src [2];
    logic [1:0]            op_fwd [2];

    assign op_src[0] = idex_rs;
    assign op_src[1] = idex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                op_fwd[gi] = 2'b00;
                // The younger result (EX/MEM) must win over MEM/WB.
                if (exmem_reg_write && exmem_rd != REG_ZERO && exmem_rd == op_src[gi]) begin
                    op_fwd[gi] = 2'b10;
                end else if (memwb_reg_write && memwb_rd != REG_ZERO && memwb_rd == op_src[gi]) begin
                    op_fwd[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign wait_cond = exmem_mem_read && !mem_ready;
    assign lu_cond   = idex_mem_read && (idex_rd != REG_ZERO) &&
                       ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

    // Mealy control; everything is forced inactive while reset is held.
    always_comb begin
        forward_a   = 2'b00;
        forward_b   = 2'b00;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (!reset) begin
            forward_a = op_fwd[0];
            forward_b = op_fwd[1];
            if (wait_cond) begin
                // A waiting load freezes everything; the bubble is deferred.
                pipe_freeze = 1'b1;
            end else if (lu_cond) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
        case (state_q)
            ST_MEM_WAIT: begin
                if (wait_cond) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 8'd1;
                end
            end
            default: begin
                if (wait_cond) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else if (lu_cond) begin
                    state_d = ST_LOAD_USE;
                end
            end
        endcase

        // Sets on the edge where the wait count reaches the limit, then sticks.
        mem_timeout_d = mem_timeout_q || (wait_cond && (wait_cnt_d >= WAIT_LIMIT));

        stall_cnt_d  = (idex_bubble && stall_cnt_q != CNT_SAT) ?
                       stall_cnt_q + CNT_ONE : stall_cnt_q;
        freeze_cnt_d = (pipe_freeze && freeze_cnt_q != CNT_SAT) ?
                       freeze_cnt_q + CNT_ONE : freeze_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 8'd0;
            stall_cnt_q   <= '0;
            freeze_cnt_q  <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            freeze_cnt_q  <= freeze_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign freeze_cnt  = freeze_cnt_q;
    assign mem_timeout = mem_timeout_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
    logic       ifid_uses_rt, idex_mem_read, exmem_reg_write, exmem_mem_read;
    logic       mem_ready, memwb_reg_write;

    // default instance
    logic [1:0]  fa, fb, st;
    logic        pcw, ifw, bub, frz, tout;
    logic [15:0] scnt, fcnt;
    // MAX_WAIT = 3 instance
    logic [1:0]  fa_m, fb_m, st_m;
    logic        pcw_m, ifw_m, bub_m, frz_m, tout_m;
    logic [15:0] scnt_m, fcnt_m;
    // CNT_W = 2 instance
    logic [1:0]  fa_c, fb_c, st_c;
    logic        pcw_c, ifw_c, bub_c, frz_c, tout_c;
    logic [1:0]  scnt_c, fcnt_c;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_fsm, m_waitcnt, m_stall, m_freeze;
    bit m_to0, m_to1;

    always #5 clk = ~clk;

    hazard_forward_ctrl dut (
        .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .mem_ready(mem_ready), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .forward_a(fa), .forward_b(fb), .pc_write(pcw), .ifid_write(ifw),
        .idex_bubble(bub), .pipe_freeze(frz), .stall_cnt(scnt), .freeze_cnt(fcnt),
        .mem_timeout(tout), .fsm_state(st));

    hazard_forward_ctrl #(.MAX_WAIT(3)) dut_mw (
        .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .mem_ready(mem_ready), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .forward_a(fa_m), .forward_b(fb_m), .pc_write(pcw_m), .ifid_write(ifw_m),
        .idex_bubble(bub_m), .pipe_freeze(frz_m), .stall_cnt(scnt_m), .freeze_cnt(fcnt_m),
        .mem_timeout(tout_m), .fsm_state(st_m));

    hazard_forward_ctrl #(.CNT_W(2)) dut_cw (
        .clk(clk), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .exmem_rd(exmem_rd),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .mem_ready(mem_ready), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .forward_a(fa_c), .forward_b(fb_c), .pc_write(pcw_c), .ifid_write(ifw_c),
        .idex_bubble(bub_c), .pipe_freeze(frz_c), .stall_cnt(scnt_c), .freeze_cnt(fcnt_c),
        .mem_timeout(tout_c), .fsm_state(st_c));

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_clear();
        m_fsm = 0; m_waitcnt = 0; m_stall = 0; m_freeze = 0; m_to0 = 0; m_to1 = 0;
    endtask

    // Advances the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        bit wt, lu;
        wt = exmem_mem_read && !mem_ready;
        lu = idex_mem_read && idex_rd != 0 &&
             (idex_rd == ifid_rs || (ifid_uses_rt && idex_rd == ifid_rt));
        if (reset) begin
            model_clear();
        end else begin
            if (wt) m_freeze++;
            else if (lu) m_stall++;
            m_waitcnt = wt ? ((m_waitcnt >= 255) ? 255 : m_waitcnt + 1) : 0;
            if (m_waitcnt >= 15) m_to0 = 1;
            if (m_waitcnt >= 3)  m_to1 = 1;
            m_fsm = wt ? 2 : ((m_fsm != 2 && lu) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_idle();
        ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0; idex_rs = 0; idex_rt = 0;
        idex_rd = 0; idex_mem_read = 0; exmem_rd = 0; exmem_reg_write = 0;
        exmem_mem_read = 0; mem_ready = 1; memwb_rd = 0; memwb_reg_write = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        exmem_reg_write = 1; exmem_rd = 3; idex_rs = 3;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        #1;
        n_vec++;
        if (fa !== 2'b00) begin n_err++; $display("FAIL reset_fwd_a: got %b want 00", fa); end
        n_vec++;
        if ({pcw, ifw, bub, frz} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000", {pcw, ifw, bub, frz});
        end
        n_vec++;
        if ({st, scnt, fcnt, tout, tout_m, scnt_c} !== '0) begin
            n_err++;
            $display("FAIL reset_state: st=%b scnt=%0d fcnt=%0d tout=%b want all 0", st, scnt, fcnt, tout);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({fa, pcw, ifw} !== 4'b1011) begin
            n_err++; $display("FAIL reset_release: got %b want 1011", {fa, pcw, ifw});
        end
        $display("txn reset done");
    endtask

    task automatic test_forwarding();
        set_idle();
        exmem_rd = 3; memwb_rd = 3; idex_rs = 3; exmem_reg_write = 1; memwb_reg_write = 1;
        #1;
        n_vec++;
        if (fa !== 2'b10) begin n_err++; $display("FAIL fwd_both_match: got %b want 10", fa); end
        exmem_reg_write = 0;
        #1;
        n_vec++;
        if (fa !== 2'b01) begin n_err++; $display("FAIL fwd_memwb: got %b want 01", fa); end
        idex_rt = 0; exmem_rd = 0; exmem_reg_write = 1; memwb_rd = 0;
        #1;
        n_vec++;
        if (fb !== 2'b00) begin n_err++; $display("FAIL fwd_zero_reg: got %b want 00", fb); end
        idex_rt = 7; memwb_rd = 7; exmem_rd = 6;
        #1;
        n_vec++;
        if (fb !== 2'b01) begin n_err++; $display("FAIL fwd_b_memwb: got %b want 01", fb); end
        $display("txn forwarding done");
    endtask

    task automatic test_load_use();
        set_idle();
        idex_mem_read = 1; idex_rd = 5; ifid_rt = 5; ifid_rs = 1; ifid_uses_rt = 0;
        #1;
        n_vec++;
        if ({bub, pcw} !== 2'b01) begin n_err++; $display("FAIL lu_rt_unused: got %b want 01", {bub, pcw}); end
        tick();
        ifid_uses_rt = 1;
        #1;
        n_vec++;
        if ({bub, pcw, ifw} !== 3'b100) begin
            n_err++; $display("FAIL lu_ctrl: got %b want 100", {bub, pcw, ifw});
        end
        n_vec++;
        if (scnt !== 16'd0) begin n_err++; $display("FAIL lu_cnt_before: got %0d want 0", scnt); end
        tick();
        n_vec++;
        if (scnt !== 16'd1 || st !== 2'b01) begin
            n_err++; $display("FAIL lu_after_edge: scnt=%0d st=%b want 1 01", scnt, st);
        end
        $display("txn load_use done");
    endtask

    task automatic test_mem_wait();
        // load-use stays true throughout; the memory wait must take priority
        exmem_mem_read = 1; mem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if ({frz, bub, pcw} !== 3'b100) begin
                n_err++; $display("FAIL wait_ctrl[%0d]: got %b want 100", k, {frz, bub, pcw});
            end
            tick();
            n_vec++;
            if (st !== 2'b10) begin n_err++; $display("FAIL wait_state[%0d]: got %b want 10", k, st); end
        end
        mem_ready = 1;
        #1;
        n_vec++;
        if ({frz, bub} !== 2'b01) begin n_err++; $display("FAIL wait_release: got %b want 01", {frz, bub}); end
        tick();
        n_vec++;
        if (fcnt !== 16'd4 || st !== 2'b00) begin
            n_err++; $display("FAIL wait_end: fcnt=%0d st=%b want 4 00", fcnt, st);
        end
        set_idle();
        tick();
        $display("txn mem_wait done");
    endtask

    task automatic test_reset_mid_wait();
        exmem_mem_read = 1; mem_ready = 0; exmem_reg_write = 1; exmem_rd = 2; idex_rs = 2;
        tick(); tick(); tick();
        n_vec++;
        if (st !== 2'b10 || fcnt === 16'd0) begin
            n_err++; $display("FAIL pre_reset_wait: st=%b fcnt=%0d want 10 nonzero", st, fcnt);
        end
        #2 reset = 1'b1;
        model_clear();
        #1;
        n_vec++;
        if ({fa, pcw, ifw, bub, frz, st, scnt, fcnt, tout_m, fcnt_m} !== '0) begin
            n_err++;
            $display("FAIL async_reset: fa=%b ctrl=%b st=%b scnt=%0d fcnt=%0d tout_m=%b want all 0",
                     fa, {pcw, ifw, bub, frz}, st, scnt, fcnt, tout_m);
        end
        set_idle();
        #1 reset = 1'b0;
        tick();
        $display("txn reset_mid_wait done");
    endtask

    task automatic test_timeout();
        exmem_mem_read = 1; mem_ready = 0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_vec++;
            if (frz_m !== 1'b1) begin n_err++; $display("FAIL to_freeze[%0d]: got %b want 1", k, frz_m); end
            tick();
            n_vec++;
            if (tout_m !== (k >= 3)) begin
                n_err++; $display("FAIL to_flag[%0d]: got %b want %b", k, tout_m, (k >= 3));
            end
        end
        mem_ready = 1;
        tick();
        n_vec++;
        if ({tout_m, st_m, tout} !== 4'b1000) begin
            n_err++; $display("FAIL to_sticky: got %b want 1000", {tout_m, st_m, tout});
        end
        mem_ready = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_vec++;
            if (tout !== (k >= 15)) begin
                n_err++; $display("FAIL to_default[%0d]: got %b want %b", k, tout, (k >= 15));
            end
        end
        mem_ready = 1;
        tick();
        set_idle();
        $display("txn timeout done");
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idex_mem_read = 1; idex_rd = 4; ifid_rs = 4;
        for (int k = 0; k < 5; k++) tick();
        n_vec++;
        if (scnt_c !== 2'd3 || scnt !== 16'd5) begin
            n_err++; $display("FAIL stall_sat: scnt_c=%0d scnt=%0d want 3 5", scnt_c, scnt);
        end
        exmem_mem_read = 1; mem_ready = 0;
        for (int k = 0; k < 6; k++) tick();
        n_vec++;
        if (fcnt_c !== 2'd3 || fcnt !== 16'd6) begin
            n_err++; $display("FAIL freeze_sat: fcnt_c=%0d fcnt=%0d want 3 6", fcnt_c, fcnt);
        end
        set_idle();
        tick();
        $display("txn saturation done");
    endtask

    task automatic test_random();
        bit wt, lu;
        logic [1:0] e_fa, e_fb;
        logic [3:0] e_ctrl;
        for (int t = 0; t < 300; t++) begin
            ifid_rs = 5'($urandom_range(0, 3));
            ifid_rt = 5'($urandom_range(0, 3));
            idex_rs = 5'($urandom_range(0, 3));
            idex_rt = 5'($urandom_range(0, 3));
            idex_rd = 5'($urandom_range(0, 3));
            exmem_rd = 5'($urandom_range(0, 3));
            memwb_rd = 5'($urandom_range(0, 3));
            ifid_uses_rt = 1'($urandom);
            idex_mem_read = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            memwb_reg_write = 1'($urandom);
            exmem_mem_read = ($urandom_range(0, 9) < 3);
            mem_ready = ($urandom_range(0, 9) < 4);
            #1;
            wt = exmem_mem_read && !mem_ready;
            lu = idex_mem_read && idex_rd != 0 &&
                 (idex_rd == ifid_rs || (ifid_uses_rt && idex_rd == ifid_rt));
            e_fa = (exmem_reg_write && exmem_rd != 0 && exmem_rd == idex_rs) ? 2'b10 :
                   (memwb_reg_write && memwb_rd != 0 && memwb_rd == idex_rs) ? 2'b01 : 2'b00;
            e_fb = (exmem_reg_write && exmem_rd != 0 && exmem_rd == idex_rt) ? 2'b10 :
                   (memwb_reg_write && memwb_rd != 0 && memwb_rd == idex_rt) ? 2'b01 : 2'b00;
            e_ctrl = wt ? 4'b0001 : (lu ? 4'b0010 : 4'b1100);
            n_vec++;
            if ({fa, fb, pcw, ifw, bub, frz} !== {e_fa, e_fb, e_ctrl} ||
                {fa_m, fb_m, pcw_m, ifw_m, bub_m, frz_m} !== {e_fa, e_fb, e_ctrl} ||
                {fa_c, fb_c, pcw_c, ifw_c, bub_c, frz_c} !== {e_fa, e_fb, e_ctrl}) begin
                n_err++;
                $display("FAIL rnd_comb[%0d]: got %b want %b", t,
                         {fa, fb, pcw, ifw, bub, frz}, {e_fa, e_fb, e_ctrl});
            end
            tick();
            n_vec++;
            if (st !== 2'(m_fsm) || st_m !== 2'(m_fsm) || st_c !== 2'(m_fsm) ||
                scnt !== 16'(sat(m_stall, 16)) || fcnt !== 16'(sat(m_freeze, 16)) ||
                scnt_c !== 2'(sat(m_stall, 2)) || fcnt_c !== 2'(sat(m_freeze, 2)) ||
                tout !== m_to0 || tout_m !== m_to1 || tout_c !== m_to0) begin
                n_err++;
                $display("FAIL rnd_state[%0d]: st=%b scnt=%0d fcnt=%0d tout=%b tout_m=%b want st=%0d scnt=%0d fcnt=%0d tout=%b tout_m=%b",
                         t, st, scnt, fcnt, tout, tout_m, m_fsm, m_stall, m_freeze, m_to0, m_to1);
            end
            $display("txn %0d: wait=%b lu=%b fa=%b fb=%b st=%b", t, wt, lu, fa, fb, st);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_reset_mid_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
